peak_meter_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel windowed peak detector in the audio meter path. It accepts a time-multiplexed stream of signed audio samples tagged with a channel index and tracks the absolute peak per channel over a programmable window of frames. At each window end it emits one result per channel on a valid/ready output stream. An optional peak-hold-with-linear-decay mode drives the IN-9 bargraph ballistics.

---
 rtl/peak_meter_mc.sv | 150 +++++++++++++++
 tb/tb_peak_meter_mc.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_meter_mc.sv
// Per-channel windowed absolute-peak meter over a channel-tagged sample stream.
// Latency: channel 0 result valid the cycle after the window-ending sample.
// Backpressure: results hold on out_ready=0; a window ending mid-emission is dropped with an overrun pulse.
module peak_meter_mc #(
  parameter  int W     = 24,
  parameter  int NCH   = 2,
  parameter  int CNT_W = 10,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] size,
  input  logic             mode,
  input  logic [W-2:0]     decay,
  input  logic             vin,
  input  logic [CW-1:0]    cin,
  input  logic [W-1:0]     din,
  output logic             vout,
  output logic [CW-1:0]    cout,
  output logic [W-2:0]     dout,
  output logic             last,
  input  logic             out_ready,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cout_q, cout_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             mode_q, mode_d;
  logic             overrun_q, overrun_d;

  logic [W-2:0] peak_q [NCH];
  logic [W-2:0] peak_d [NCH];
  logic [W-2:0] peak_upd [NCH];
  logic [W-2:0] snap_q [NCH];
  logic [W-2:0] snap_d [NCH];
  logic [W-2:0] held_q [NCH];
  logic [W-2:0] held_d [NCH];
  logic [W-2:0] held_dec [NCH];
  logic [W-2:0] held_new [NCH];

  logic [W-1:0] neg;
  logic [W-2:0] mag;
  logic         sample_ok, frame_end, win_end, final_hs, accept;

  // Absolute value of the incoming sample; the most negative code saturates.
  always_comb begin
    neg = -din;
    mag = din[W-2:0];
    if (din[W-1]) begin
      if (din[W-2:0] == '0) mag = '1;
      else                  mag = neg[W-2:0];
    end
  end

  // Frame / window boundary detection; out-of-range channels are ignored.
  always_comb begin
    sample_ok = vin && (32'(cin) < NCH);
    frame_end = sample_ok && (cin == LAST_CH);
    count_inc = count_q + CNT_W'(1);
    win_end   = frame_end && (count_inc == size);
    final_hs  = (state_q == EMIT) && out_ready && (cout_q == LAST_CH);
    // A window result is only taken when the emitter is free or frees up this cycle.
    accept    = win_end && ((state_q == IDLE) || final_hs);
    overrun_d = win_end && !accept;
    if (win_end)        count_d = '0;
    else if (frame_end) count_d = count_inc;
    else                count_d = count_q;
  end

  // Peak tracking, snapshot capture and held-value decay per channel.
  always_comb begin
    mode_d = accept ? mode : mode_q;
    for (int c = 0; c < NCH; c++) begin
      peak_upd[c] = peak_q[c];
      if (sample_ok && (cin == CW'(c)) && (mag > peak_q[c])) peak_upd[c] = mag;
      peak_d[c]   = win_end ? '0 : peak_upd[c];
      held_dec[c] = (held_q[c] > decay) ? (held_q[c] - decay) : '0;
      held_new[c] = (peak_upd[c] > held_dec[c]) ? peak_upd[c] : held_dec[c];
      snap_d[c]   = accept ? peak_upd[c] : snap_q[c];
      held_d[c]   = accept ? held_new[c] : held_q[c];
    end
  end

  // Output FSM next state: walk channels 0..NCH-1, restart if a window lands on the last handshake.
  always_comb begin
    state_d = state_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
          cout_d  = '0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (cout_q == LAST_CH) begin
            cout_d  = '0;
            state_d = accept ? EMIT : IDLE;
          end else begin
            cout_d = cout_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cout_d  = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cout_q    <= '0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        peak_q[c] <= '0;
        snap_q[c] <= '0;
        held_q[c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cout_q    <= cout_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
      for (int c = 0; c < NCH; c++) begin
        peak_q[c] <= peak_d[c];
        snap_q[c] <= snap_d[c];
        held_q[c] <= held_d[c];
      end
    end
  end

  assign vout    = (state_q == EMIT);
  assign cout    = cout_q;
  assign dout    = mode_q ? held_q[cout_q] : snap_q[cout_q];
  assign last    = vout && (cout_q == LAST_CH);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_peak_meter_mc.sv
module tb_peak_meter_mc;
  localparam int NCH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  size;
  logic        mode;
  logic [22:0] decay;
  logic        vin;
  logic [0:0]  cin;
  logic [23:0] din;
  logic        vout;
  logic [0:0]  cout;
  logic [22:0] dout;
  logic        last;
  logic        out_ready;
  logic        overrun;

  // second instance with three channels so an out-of-range index is representable
  logic        vin3;
  logic [1:0]  cin3;
  logic [23:0] din3;
  logic        vout3;
  logic [1:0]  cout3;
  logic [22:0] dout3;
  logic        last3;
  logic        overrun3;

  always #5 clk = ~clk;

  peak_meter_mc #(.W(24), .NCH(2), .CNT_W(10)) u_dut (
    .clk(clk), .rst(rst), .size(size), .mode(mode), .decay(decay),
    .vin(vin), .cin(cin), .din(din), .vout(vout), .cout(cout), .dout(dout),
    .last(last), .out_ready(out_ready), .overrun(overrun)
  );

  peak_meter_mc #(.W(24), .NCH(3), .CNT_W(10)) u_dut3 (
    .clk(clk), .rst(rst), .size(size), .mode(mode), .decay(decay),
    .vin(vin3), .cin(cin3), .din(din3), .vout(vout3), .cout(cout3), .dout(dout3),
    .last(last3), .out_ready(out_ready), .overrun(overrun3)
  );

  typedef struct {
    int          ch;
    logic [22:0] dat;
    bit          lst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [22:0] m_peak [NCH];
  logic [22:0] m_held [NCH];
  int          m_cnt;
  bit          m_drop;

  function automatic logic [22:0] mag_f(input logic [23:0] v);
    logic [23:0] n;
    if (v == 24'h800000) return 23'h7FFFFF;
    if (v[23]) begin
      n = ~v + 24'd1;
      return n[22:0];
    end
    return v[22:0];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_peak[c] = '0;
      m_held[c] = '0;
    end
    m_cnt  = 0;
    m_drop = 0;
    exp_q.delete();
  endtask

  task automatic send(input int ch, input logic [23:0] v);
    logic [22:0] dec;
    exp_t        e;
    vin = 1'b1;
    cin = 1'(ch);
    din = v;
    @(posedge clk);
    #1;
    vin = 1'b0;
    if (mag_f(v) > m_peak[ch]) m_peak[ch] = mag_f(v);
    if (ch == NCH - 1) begin
      if (((m_cnt + 1) % 1024) == int'(size)) begin
        for (int c = 0; c < NCH; c++) begin
          if (!m_drop) begin
            dec = (m_held[c] > decay) ? m_held[c] - decay : 23'd0;
            m_held[c] = (m_peak[c] > dec) ? m_peak[c] : dec;
            e.ch  = c;
            e.dat = mode ? m_held[c] : m_peak[c];
            e.lst = (c == NCH - 1);
            exp_q.push_back(e);
          end
          m_peak[c] = '0;
        end
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % 1024;
      end
    end
  endtask

  task automatic send3(input int ch, input logic [23:0] v);
    vin3 = 1'b1;
    cin3 = 2'(ch);
    din3 = v;
    @(posedge clk);
    #1;
    vin3 = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !vout) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // scoreboard: every accepted output word is popped and compared
  always @(negedge clk) begin
    if (!rst && vout && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected cout=%0d dout=%h required no output", cout, dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (cout !== 1'(mon_e.ch) || dout !== mon_e.dat || last !== mon_e.lst) begin
          failures++;
          $display("FAIL out_word got ch=%0d dout=%h last=%0b required ch=%0d dout=%h last=%0b",
                   cout, dout, last, mon_e.ch, mon_e.dat, mon_e.lst);
        end
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if (vout !== 1'b0 || cout !== 1'b0 || dout !== 23'd0 || last !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got vout=%0b cout=%0d dout=%h last=%0b overrun=%0b required all 0",
               vout, cout, dout, last, overrun);
    end
    checks++;
    if (vout3 !== 1'b0 || overrun3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut3 got vout=%0b overrun=%0b required 0", vout3, overrun3);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    bit ok;
    logic [23:0] c0 [4] = '{24'h000100, 24'hFFF000, 24'h000010, 24'h000000};
    logic [23:0] c1 [4] = '{24'h7FFFFF, 24'h0, 24'h0, 24'h0};
    for (int f = 0; f < 4; f++) begin
      send(0, c0[f]);
      send(1, c1[f]);
    end
    checks++;
    if (vout !== 1'b1 || cout !== 1'b0 || dout !== 23'h001000 || last !== 1'b0) begin
      failures++;
      $display("FAIL basic_ch0 got vout=%0b cout=%0d dout=%h required 1 0 001000", vout, cout, dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (vout !== 1'b1 || cout !== 1'b1 || dout !== 23'h7FFFFF || last !== 1'b1) begin
      failures++;
      $display("FAIL basic_ch1 got vout=%0b cout=%0d dout=%h last=%0b required 1 1 7fffff 1",
               vout, cout, dout, last);
    end
    @(posedge clk);
    #1;
    checks++;
    if (vout !== 1'b0) begin
      failures++;
      $display("FAIL basic_done got vout=%0b required 0", vout);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_saturate();
    bit ok;
    send(0, 24'h800000);
    send(1, 24'h000001);
    for (int f = 0; f < 3; f++) begin
      send(0, 24'h0);
      send(1, 24'h0);
    end
    checks++;
    if (vout !== 1'b1 || dout !== 23'h7FFFFF) begin
      failures++;
      $display("FAIL saturate got vout=%0b dout=%h required 1 7fffff", vout, dout);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL saturate_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_ignore();
    logic [22:0] want [3] = '{23'h10, 23'h20, 23'h30};
    send3(0, 24'h10);
    send3(3, 24'h400000);
    send3(1, 24'h20);
    send3(3, 24'h400000);
    send3(2, 24'h30);
    for (int f = 0; f < 2; f++) begin
      send3(0, 24'h0);
      send3(3, 24'h400000);
      send3(1, 24'h0);
      send3(2, 24'h0);
    end
    send3(0, 24'h0);
    send3(1, 24'h0);
    send3(3, 24'h400000);
    checks++;
    if (vout3 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_early got vout=%0b required 0", vout3);
    end
    send3(2, 24'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (vout3 !== 1'b1 || cout3 !== 2'(c) || dout3 !== want[c] || last3 !== (c == 2)) begin
        failures++;
        $display("FAIL ignore_out%0d got vout=%0b cout=%0d dout=%h last=%0b required 1 %0d %h %0b",
                 c, vout3, cout3, dout3, last3, c, want[c], (c == 2));
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (vout3 !== 1'b0 || overrun3 !== 1'b0) begin
      failures++;
      $display("FAIL ignore_done got vout=%0b overrun=%0b required 0 0", vout3, overrun3);
    end
  endtask

  task automatic test_decay();
    bit ok;
    do_reset();
    mode  = 1'b1;
    decay = 23'h000100;
    for (int w = 0; w < 19; w++) begin
      for (int f = 0; f < 4; f++) begin
        send(0, (w == 0 && f == 0) ? 24'h001000 : 24'h0);
        send(1, 24'h0);
      end
      if (w == 0 || w == 1 || w == 2 || w == 18) begin
        checks++;
        if (vout !== 1'b1 || dout !== ((w == 18) ? 23'h0 : 23'(23'h001000 - 23'(w * 256)))) begin
          failures++;
          $display("FAIL decay_w%0d got vout=%0b dout=%h", w, vout, dout);
        end
      end
    end
    wait_idle(ok);
    mode = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL decay_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    send(0, 24'h000111);
    send(1, 24'h000222);
    for (int f = 0; f < 3; f++) begin send(0, 24'h0); send(1, 24'h0); end
    m_drop = 1;
    send(0, 24'h000333);
    send(1, 24'h000444);
    for (int f = 0; f < 3; f++) begin send(0, 24'h0); send(1, 24'h0); end
    m_drop = 0;
    checks++;
    if (overrun !== 1'b1 || vout !== 1'b1 || cout !== 1'b0 || dout !== 23'h000111) begin
      failures++;
      $display("FAIL overrun_pulse got overrun=%0b vout=%0b cout=%0d dout=%h required 1 1 0 000111",
               overrun, vout, cout, dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_width got overrun=%0b required 0", overrun);
    end
    out_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL overrun_drain pending=%0d required 0", exp_q.size());
    end
    out_ready = 1'b0;
    send(0, 24'h000555);
    send(1, 24'h000666);
    for (int f = 0; f < 3; f++) begin send(0, 24'h0); send(1, 24'h0); end
    send(0, 24'h000777);
    out_ready = 1'b1;
    send(1, 24'h000888);
    out_ready = 1'b0;
    send(0, 24'h0); send(1, 24'h0); send(0, 24'h0); send(1, 24'h0); send(0, 24'h0);
    out_ready = 1'b1;
    send(1, 24'h0);
    checks++;
    if (overrun !== 1'b0 || vout !== 1'b1 || cout !== 1'b0 || dout !== 23'h000777) begin
      failures++;
      $display("FAIL coincide got overrun=%0b vout=%0b cout=%0d dout=%h required 0 1 0 000777",
               overrun, vout, cout, dout);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL coincide_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_size0();
    bit ok;
    size = 10'd0;
    for (int f = 0; f < 1024; f++) begin
      send(0, 24'($urandom));
      if (f == 1023) begin
        checks++;
        if (vout !== 1'b0) begin
          failures++;
          $display("FAIL size0_early got vout=%0b required 0", vout);
        end
      end
      send(1, 24'($urandom));
    end
    checks++;
    if (vout !== 1'b1) begin
      failures++;
      $display("FAIL size0_result got vout=%0b required 1", vout);
    end
    wait_idle(ok);
    size = 10'd4;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL size0_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    send(0, 24'h7FFFFF);
    send(1, 24'h0);
    for (int f = 0; f < 3; f++) begin send(0, 24'h0); send(1, 24'h0); end
    rst = 1'b1;
    #1;
    checks++;
    if (vout !== 1'b0 || cout !== 1'b0 || last !== 1'b0 || dout !== 23'd0) begin
      failures++;
      $display("FAIL rst_async got vout=%0b cout=%0d last=%0b dout=%h required all 0",
               vout, cout, last, dout);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    send(0, 24'h700000);
    send(1, 24'h600000);
    do_reset();
    out_ready = 1'b1;
    send(0, 24'h000012);
    send(1, 24'h000034);
    for (int f = 0; f < 3; f++) begin send(0, 24'h0); send(1, 24'h0); end
    checks++;
    if (vout !== 1'b1 || dout !== 23'h000012) begin
      failures++;
      $display("FAIL rst_post got vout=%0b dout=%h required 1 000012", vout, dout);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    size      = 10'd4;
    mode      = 1'b0;
    decay     = 23'd0;
    vin       = 1'b0;
    cin       = 1'b0;
    din       = 24'd0;
    vin3      = 1'b0;
    cin3      = 2'd0;
    din3      = 24'd0;
    out_ready = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_saturate();
    test_ignore();
    test_decay();
    test_overrun();
    test_size0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
